// File: rtl/naval_display_scan_if.sv
`default_nettype none
// ============================================================================
// Interface : naval_display_scan_if
// Brief     : Content/handshake and pin bundle between game control and the
//             multiplexed 7-segment display driver.
// Revision  : 1.0 - initial release
// ============================================================================
interface naval_display_scan_if #(
  parameter int NDIG = 4
);
  logic                    mode;
  logic [4*(NDIG-1)-1:0]   data;
  logic [NDIG-1:0]         blank;
  logic [NDIG-1:0]         blink;
  logic                    load;
  logic                    ack;
  logic [6:0]              seg;
  logic [NDIG-1:0]         dig;
  logic                    frame;

  // Game control side: supplies content, observes handshake and pins.
  modport master (
    output mode, data, blank, blink, load,
    input  ack, seg, dig, frame
  );

  // Display driver side.
  modport slave (
    input  mode, data, blank, blink, load,
    output ack, seg, dig, frame
  );
endinterface
`default_nettype wire

// File: rtl/naval_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : naval_display_scan
// Brief    : Time-multiplexed NDIG-digit common-anode 7-segment driver with
//            frame-synchronous shadow loading, per-digit blank and blink.
// Revision : 1.0 - initial release
// ============================================================================
module naval_display_scan #(
  parameter int NDIG         = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input wire                  clk_i,
  input wire                  rstn_i,
  naval_display_scan_if.slave disp_if
);

  localparam int c_DW     = 4 * (NDIG - 1);
  localparam int c_DIV_W  = $clog2(SCAN_DIV);
  localparam int c_IDX_W  = $clog2(NDIG);
  localparam int c_FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NDIG - 1);
  localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(BLINK_FRAMES - 1);

  localparam logic [6:0] c_SEG_OFF = 7'b1111111;
  localparam logic [6:0] c_SEG_P   = 7'b0011000;
  localparam logic [6:0] c_SEG_A   = 7'b0001000;

  logic [c_DIV_W-1:0]  div_q,   div_d;
  logic [c_IDX_W-1:0]  idx_q,   idx_d;
  logic [c_FCNT_W-1:0] fcnt_q,  fcnt_d;
  logic                phase_q, phase_d;
  logic                pending_q, pending_d;
  logic                mode_q,  mode_d;
  logic [c_DW-1:0]     data_q,  data_d;
  logic [NDIG-1:0]     blank_q, blank_d;
  logic [NDIG-1:0]     blink_q, blink_d;
  logic                ack_q,   ack_d;
  logic                frame_q, frame_d;

  logic                w_tick;
  logic                w_bnd;
  logic                w_take;
  logic                w_dark;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg;
  logic [NDIG-1:0]     w_dig;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  // Scan timing, frame-boundary shadow capture and blink phase.
  always_comb begin
    w_tick    = (div_q == c_DIV_LAST);
    w_bnd     = w_tick && (idx_q == c_IDX_LAST);
    w_take    = w_bnd && (pending_q || disp_if.load);

    div_d     = w_tick ? '0 : div_q + 1'b1;
    idx_d     = idx_q;
    if (w_tick) begin
      idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // A LOAD on the boundary itself is consumed there, so it must not re-arm.
    pending_d = w_bnd ? 1'b0 : (pending_q || disp_if.load);

    fcnt_d    = fcnt_q;
    phase_d   = phase_q;
    if (w_bnd) begin
      if (fcnt_q == c_FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + 1'b1;
      end
    end

    mode_d    = w_take ? disp_if.mode  : mode_q;
    data_d    = w_take ? disp_if.data  : data_q;
    blank_d   = w_take ? disp_if.blank : blank_q;
    blink_d   = w_take ? disp_if.blink : blink_q;
    ack_d     = w_take;
    frame_d   = w_bnd;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_q     <= '0;
      idx_q     <= '0;
      fcnt_q    <= '0;
      phase_q   <= 1'b0;
      pending_q <= 1'b0;
      mode_q    <= 1'b0;
      data_q    <= '0;
      blank_q   <= '1;
      blink_q   <= '0;
      ack_q     <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      fcnt_q    <= fcnt_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      blank_q   <= blank_d;
      blink_q   <= blink_d;
      ack_q     <= ack_d;
      frame_q   <= frame_d;
    end
  end

  // Pin decode is a pure function of registered state, so inputs never
  // reach the pins combinationally.
  always_comb begin
    w_dark = 1'b1;
    w_nib  = 4'h0;
    w_dig  = '1;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == c_IDX_W'(k)) begin
        w_dark = blank_q[k] | (blink_q[k] & phase_q);
        if (div_q != '0) begin
          w_dig[k] = 1'b0;
        end
      end
    end
    for (int k = 0; k < NDIG - 1; k++) begin
      if (idx_q == c_IDX_W'(k)) begin
        w_nib = data_q[4*k +: 4];
      end
    end

    if (w_dark) begin
      w_seg = c_SEG_OFF;
    end else if (idx_q == c_IDX_LAST) begin
      w_seg = mode_q ? c_SEG_A : c_SEG_P;
    end else begin
      w_seg = hex_glyph(w_nib);
    end
  end

  assign disp_if.seg   = w_seg;
  assign disp_if.dig   = w_dig;
  assign disp_if.ack   = ack_q;
  assign disp_if.frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_naval_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_naval_display_scan
// Brief    : Directed self-checking bench, NDIG=4 SCAN_DIV=4 BLINK_FRAMES=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_naval_display_scan;

  localparam logic [6:0] c_OFF = 7'b1111111;
  localparam logic [6:0] c_G0  = 7'b0000001;
  localparam logic [6:0] c_G1  = 7'b1001111;
  localparam logic [6:0] c_G2  = 7'b0010010;
  localparam logic [6:0] c_G3  = 7'b0000110;
  localparam logic [6:0] c_G4  = 7'b1001100;
  localparam logic [6:0] c_GC  = 7'b0110001;
  localparam logic [6:0] c_GE  = 7'b0110000;
  localparam logic [6:0] c_GF  = 7'b0111000;
  localparam logic [6:0] c_GA  = 7'b0001000;
  localparam logic [6:0] c_GP  = 7'b0011000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  naval_display_scan_if #(.NDIG(4)) disp_if ();

  naval_display_scan #(
    .NDIG         (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) u_dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .disp_if (disp_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at div=0/idx=0; checks one whole frame and ends at the next one.
  task automatic check_frame(input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3,
                             input logic exp_frame, input logic exp_ack,
                             input bit pulse_load);
    logic [6:0] g [4];
    logic [3:0] ed;
    g = '{g0, g1, g2, g3};
    chk("frame_at_start", disp_if.frame, exp_frame);
    chk("ack_at_start",   disp_if.ack,   exp_ack);
    for (int c = 0; c < 16; c++) begin
      ed = 4'hF;
      if (c % 4 != 0) ed[c/4] = 1'b0;
      chk("dig", disp_if.dig, ed);
      chk("seg", disp_if.seg, g[c/4]);
      if (c != 0) begin
        chk("frame_mid", disp_if.frame, 1'b0);
        chk("ack_mid",   disp_if.ack,   1'b0);
      end
      step();
      if (pulse_load && c == 0) disp_if.load = 1'b0;
    end
  endtask

  initial begin
    disp_if.mode  = 1'b0;
    disp_if.data  = 12'h000;
    disp_if.blank = 4'h0;
    disp_if.blink = 4'h0;
    disp_if.load  = 1'b0;

    // Power-on reset
    step();
    step();
    chk("rst_dig",   disp_if.dig,   4'hF);
    chk("rst_seg",   disp_if.seg,   c_OFF);
    chk("rst_ack",   disp_if.ack,   1'b0);
    chk("rst_frame", disp_if.frame, 1'b0);
    rstn = 1'b1;

    // F0: dark until first load
    check_frame(c_OFF, c_OFF, c_OFF, c_OFF, 1'b0, 1'b0, 1'b0);

    // F1: LOAD 321/mode A one cycle; old (dark) content stays until boundary
    disp_if.data = 12'h321;
    disp_if.mode = 1'b1;
    disp_if.load = 1'b1;
    check_frame(c_OFF, c_OFF, c_OFF, c_OFF, 1'b1, 1'b0, 1'b1);
    // F2: new content, single ACK
    check_frame(c_G1, c_G2, c_G3, c_GA, 1'b1, 1'b1, 1'b0);

    // F3: load BLINK=0001 (phase currently 1)
    disp_if.blink = 4'b0001;
    disp_if.load  = 1'b1;
    check_frame(c_G1, c_G2, c_G3, c_GA, 1'b1, 1'b0, 1'b1);
    // F4..F8: phase 0,0,1,1,0
    check_frame(c_G1,  c_G2, c_G3, c_GA, 1'b1, 1'b1, 1'b0);
    check_frame(c_G1,  c_G2, c_G3, c_GA, 1'b1, 1'b0, 1'b0);
    check_frame(c_OFF, c_G2, c_G3, c_GA, 1'b1, 1'b0, 1'b0);
    check_frame(c_OFF, c_G2, c_G3, c_GA, 1'b1, 1'b0, 1'b0);
    check_frame(c_G1,  c_G2, c_G3, c_GA, 1'b1, 1'b0, 1'b0);

    // F9: coalesced loads, second held through the boundary
    disp_if.data  = 12'h111;
    disp_if.blink = 4'b0000;
    disp_if.load  = 1'b1;
    step();
    disp_if.load  = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("coalesce_no_ack", disp_if.ack, 1'b0);
      if (i == 2) begin
        disp_if.data = 12'hF0E;
        disp_if.load = 1'b1;
      end
      step();
    end
    disp_if.load = 1'b0;
    // F10: one ACK, shows E,0,F,A
    check_frame(c_GE, c_G0, c_GF, c_GA, 1'b1, 1'b1, 1'b0);

    // F11: LOAD only on the boundary cycle
    for (int i = 0; i < 15; i++) begin
      chk("pre_bnd_no_ack", disp_if.ack, 1'b0);
      step();
    end
    disp_if.data  = 12'h7C4;
    disp_if.mode  = 1'b0;
    disp_if.blank = 4'b0100;
    disp_if.load  = 1'b1;
    step();
    disp_if.load  = 1'b0;
    // F12: 4,C,dark,P
    check_frame(c_G4, c_GC, c_OFF, c_GP, 1'b1, 1'b1, 1'b0);

    // F13: pending load, then reset at div=2 idx=1
    step();
    step();
    disp_if.data  = 12'h888;
    disp_if.blank = 4'b0000;
    disp_if.load  = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_dig", disp_if.dig, 4'b1101);
    chk("pre_rst_seg", disp_if.seg, c_GC);
    rstn = 1'b0;
    #1;
    chk("midrst_dig", disp_if.dig, 4'hF);
    chk("midrst_seg", disp_if.seg, c_OFF);
    chk("midrst_ack", disp_if.ack, 1'b0);
    // LOAD held while in reset must be ignored
    step();
    step();
    disp_if.load = 1'b0;
    rstn = 1'b1;
    check_frame(c_OFF, c_OFF, c_OFF, c_OFF, 1'b0, 1'b0, 1'b0);
    check_frame(c_OFF, c_OFF, c_OFF, c_OFF, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/naval_display_scan.md
# naval_display_scan

Time-multiplexed, parametrised driver for the battleship device's common-anode 7-segment display bank. It generalises the single-digit mode indicator to NDIG digits:
- NDIG-1 hex digits plus one mode-glyph digit.
- Per-digit blanking and blinking.
- Tear-free loading of new content at frame boundaries.

It sits between the game control FSM and the board display pins.

## Interface
- NDIG, 4, number of digits, 2..8; digit NDIG-1 is the mode digit.
- SCAN_DIV, 50000, clock cycles per digit slot, ≥2.
- BLINK_FRAMES, 64, frames per blink half-period, ≥1.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- MODE  in  1  game mode: 0 = positioning ("P"), 1 = attack ("A").
- DATA  in  4*(NDIG-1)  hex values; DATA[4k+3:4k] drives digit k.
- BLANK  in  NDIG  1 = digit k is dark.
- BLINK  in  NDIG  1 = digit k blinks.
- LOAD  in  1  request to take MODE/DATA/BLANK/BLINK into the shadow registers.
- ACK  out  1  one-cycle pulse when the shadow registers are updated.
- SEG  out  7  segments, active-low: SEG[6]=a … SEG[0]=g.
- DIG  out  NDIG  digit enables, active-low, at most one low.
- FRAME  out  1  one-cycle pulse at each frame end.

## Operation
- **Slot counter** `div`: counts 0..SCAN_DIV-1 and wraps. `tick` = (div == SCAN_DIV-1).
- **Digit index** `idx`: 0..NDIG-1, advances on `tick`, wraps NDIG-1→0.
- **Frame boundary** = `tick` with idx == NDIG-1.
- **Shadow registers**: MODE, DATA, BLANK and BLINK are shadowed; the display uses only shadow values.
  - LOAD sets a pending flag.
  - At a frame boundary, if pending is set or LOAD is high that cycle: shadows take the input values present on that boundary cycle, pending clears, and ACK pulses the following cycle.
  - Repeated LOADs before a boundary coalesce into one ACK.
- **Blink**:
  - `fcnt` counts frames 0..BLINK_FRAMES-1; at wrap, `phase` toggles.
  - Digit k is dark when shadow BLANK[k] is set, or when (shadow BLINK[k] and phase == 1).
- **Glyphs** (SEG, active-low, bit order abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Mode digit: MODE 0 → "P" 0011000; MODE 1 → "A" 0001000.
  - Dark digit → 1111111.
- **Outputs**: SEG, DIG, ACK and FRAME depend on registered state only; there is no combinational path from any input to any output.

## Timing
- **Reset (RSTN low)**, values take effect immediately and asynchronously:
  - div=0, idx=0, fcnt=0, phase=0, pending=0.
  - Shadow DATA=0, shadow MODE=0, shadow BLINK=0, shadow BLANK=all ones.
  - SEG=7'h7F, DIG=all ones, ACK=0, FRAME=0.
  - The display stays dark until the first accepted LOAD.
- **Dead time**: in the cycle where div==0, DIG is all ones. For div 1..SCAN_DIV-1, DIG[idx]=0.
- **SEG** shows the glyph for idx for the whole slot.
- **Periods**:
  - Slot = SCAN_DIV cycles.
  - Frame = NDIG·SCAN_DIV cycles.
  - Blink half-period = BLINK_FRAMES frames.
- **FRAME and ACK** are asserted in the cycle after the frame-boundary edge, for exactly one cycle.
- **Load latency**: worst-case LOAD→ACK is NDIG·SCAN_DIV cycles. New content is visible from the slot-0 that starts at that boundary.
- **Reset mid-frame**: any pending LOAD is lost and no ACK is issued.

## Test plan
NDIG=4, SCAN_DIV=4, BLINK_FRAMES=2.
- **Reset mid-scan**: pull RSTN low at div=2, idx=1 → same cycle DIG=1111, SEG=1111111, ACK=0. After release, the first full frame is fully dark.
- **First load**: LOAD one cycle with DATA=12'h321, MODE=1, BLANK=0, BLINK=0 → exactly one ACK within 16 cycles. The next frame shows, on DIG=1110/1101/1011/0111 respectively, SEG=1001111/0010010/0000110/0001000.
- **Dead time**: every slot shows DIG=1111 for 1 cycle, then one-cold for 3 cycles. FRAME pulses every 16 cycles.
- **Blink**: load BLINK=0001 → digit 0 lit for 2 frames, dark for 2 frames, repeating; digits 1..3 steady.
- **Coalesced loads**: LOAD with DATA=12'h111, then LOAD with DATA=12'hF0E held until the boundary → one ACK; the display shows E,0,F.
- **Load on boundary**: LOAD only on a boundary cycle → accepted, ACK next cycle. LOAD while RSTN low → no ACK after release.
